axi_lite_reg_slave: RTL and testbench

// AXI4-Lite responder: a bank of NUM_REGS read/write 32-bit registers. It sits on
// one master port (m1_*/m2_*) of the bus interconnect and terminates its requests.
// It completes the write (AW/W/B) and read (AR/R) handshakes the interconnect

---
 rtl/axi_lite_reg_slave.sv | 176 +++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS word-spaced registers behind independent
// write (AW/W/B) and read (AR/R) responders, with per-register commit pulses.
module axi_lite_reg_slave #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    RESP_WIDTH = 3,
   parameter int                    NUM_REGS   = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                           s0_axi_aclk,
   input  logic                           s0_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
   input  logic                           s0_axi_awvalid,
   output logic                           s0_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
   input  logic [DATA_WIDTH/8:0]          s0_axi_wstrb,
   input  logic                           s0_axi_wvalid,
   output logic                           s0_axi_wready,
   output logic [RESP_WIDTH-1:0]          s0_axi_bresp,
   output logic                           s0_axi_bvalid,
   input  logic                           s0_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
   input  logic                           s0_axi_arvalid,
   output logic                           s0_axi_arready,
   output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
   output logic [RESP_WIDTH-1:0]          s0_axi_rresp,
   output logic                           s0_axi_rvalid,
   input  logic                           s0_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH:0]   SPAN        = (ADDR_WIDTH+1)'(4 * NUM_REGS);
   localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
   localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

   localparam logic [1:0] W_IDLE    = 2'd0;
   localparam logic [1:0] W_COLLECT = 2'd1;
   localparam logic [1:0] W_COMMIT  = 2'd2;
   localparam logic [1:0] W_RESP    = 2'd3;
   localparam logic [0:0] R_IDLE    = 1'b0;
   localparam logic [0:0] R_RESP    = 1'b1;

   logic [1:0]            w_state;
   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic                  aw_have;
   logic                  w_have;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]     w_strb;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic                  aw_hs;
   logic                  w_hs;
   logic                  aw_have_nxt;
   logic                  w_have_nxt;
   logic [ADDR_WIDTH:0]   aw_diff;
   logic [ADDR_WIDTH:0]   ar_diff;
   logic                  aw_hit;
   logic                  ar_hit;
   logic [IDX_W-1:0]      aw_idx;
   logic [IDX_W-1:0]      ar_idx;
   logic                  unused_strb_msb;

   assign aw_hs       = s0_axi_awvalid & s0_axi_awready;
   assign w_hs        = s0_axi_wvalid & s0_axi_wready;
   assign aw_have_nxt = aw_have | aw_hs;
   assign w_have_nxt  = w_have | w_hs;

   // A borrow on the widened subtraction lands above SPAN, so one compare covers both bounds
   assign aw_diff = {1'b0, aw_addr} - {1'b0, BASE_ADDR};
   assign ar_diff = {1'b0, s0_axi_araddr} - {1'b0, BASE_ADDR};
   assign aw_hit  = (aw_diff < SPAN) && (aw_addr[1:0] == 2'b00);
   assign ar_hit  = (ar_diff < SPAN) && (s0_axi_araddr[1:0] == 2'b00);
   assign aw_idx  = aw_diff[IDX_W+1:2];
   assign ar_idx  = ar_diff[IDX_W+1:2];

   assign unused_strb_msb = s0_axi_wstrb[STRB_W];

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
      assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
   end

   // Write side: collect AW and W in any order, commit for one cycle, then hold B until accepted
   always_ff @(posedge s0_axi_aclk) begin
      if (!s0_axi_aresetn) begin
         w_state        <= W_IDLE;
         s0_axi_awready <= 1'b0;
         s0_axi_wready  <= 1'b0;
         s0_axi_bvalid  <= 1'b0;
         s0_axi_bresp   <= '0;
         aw_have        <= 1'b0;
         w_have         <= 1'b0;
         aw_addr        <= '0;
         w_data         <= '0;
         w_strb         <= '0;
         wr_pulse       <= '0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      end else begin
         wr_pulse <= '0;
         case (w_state)
            W_IDLE, W_COLLECT: begin
               if (aw_hs) aw_addr <= s0_axi_awaddr;
               if (w_hs) begin
                  w_data <= s0_axi_wdata;
                  w_strb <= s0_axi_wstrb[STRB_W-1:0];
               end
               aw_have        <= aw_have_nxt;
               w_have         <= w_have_nxt;
               s0_axi_awready <= ~aw_have_nxt;
               s0_axi_wready  <= ~w_have_nxt;
               if (aw_have_nxt && w_have_nxt)     w_state <= W_COMMIT;
               else if (aw_have_nxt || w_have_nxt) w_state <= W_COLLECT;
               else                               w_state <= W_IDLE;
            end
            W_COMMIT: begin
               if (aw_hit) begin
                  for (int b = 0; b < STRB_W; b++)
                     if (w_strb[b]) regs[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
                  wr_pulse[aw_idx] <= 1'b1;
               end
               s0_axi_bvalid <= 1'b1;
               s0_axi_bresp  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
               w_state       <= W_RESP;
            end
            W_RESP: begin
               if (s0_axi_bready) begin
                  s0_axi_bvalid  <= 1'b0;
                  aw_have        <= 1'b0;
                  w_have         <= 1'b0;
                  s0_axi_awready <= 1'b1;
                  s0_axi_wready  <= 1'b1;
                  w_state        <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read side: regs is sampled before any same-edge commit lands, so a collision returns old data
   always_ff @(posedge s0_axi_aclk) begin
      if (!s0_axi_aresetn) begin
         r_state        <= R_IDLE;
         s0_axi_arready <= 1'b0;
         s0_axi_rvalid  <= 1'b0;
         s0_axi_rdata   <= '0;
         s0_axi_rresp   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (s0_axi_arvalid && s0_axi_arready) begin
                  s0_axi_arready <= 1'b0;
                  s0_axi_rvalid  <= 1'b1;
                  s0_axi_rdata   <= ar_hit ? regs[ar_idx] : '0;
                  s0_axi_rresp   <= ar_hit ? RESP_OKAY : RESP_SLVERR;
                  r_state        <= R_RESP;
               end else begin
                  s0_axi_arready <= 1'b1;
               end
            end
            R_RESP: begin
               if (s0_axi_rready) begin
                  s0_axi_rvalid  <= 1'b0;
                  s0_axi_arready <= 1'b1;
                  r_state        <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: a transaction-level register model
// predicts register contents, pulses and responses, compared on every falling edge.
module tb_axi_lite_reg_slave;

   localparam int BASE = 0;
   localparam int NR   = 4;

   logic         clk = 1'b0;
   logic         aresetn;
   logic [7:0]   awaddr;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [4:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [2:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [7:0]   araddr;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [2:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [127:0] regs_out;
   logic [3:0]   wr_pulse;

   int tests  = 0;
   int failed = 0;
   bit chk_en = 1'b0;

   logic [31:0] m_regs [NR];
   logic [3:0]  m_pulse;
   logic        m_bvalid;
   logic [2:0]  m_bresp;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic [2:0]  m_rresp;

   always #5 clk = ~clk;

   axi_lite_reg_slave dut (
      .s0_axi_aclk    (clk),
      .s0_axi_aresetn (aresetn),
      .s0_axi_awaddr  (awaddr),
      .s0_axi_awvalid (awvalid),
      .s0_axi_awready (awready),
      .s0_axi_wdata   (wdata),
      .s0_axi_wstrb   (wstrb),
      .s0_axi_wvalid  (wvalid),
      .s0_axi_wready  (wready),
      .s0_axi_bresp   (bresp),
      .s0_axi_bvalid  (bvalid),
      .s0_axi_bready  (bready),
      .s0_axi_araddr  (araddr),
      .s0_axi_arvalid (arvalid),
      .s0_axi_arready (arready),
      .s0_axi_rdata   (rdata),
      .s0_axi_rresp   (rresp),
      .s0_axi_rvalid  (rvalid),
      .s0_axi_rready  (rready),
      .regs_out       (regs_out),
      .wr_pulse       (wr_pulse)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit modelHit(input logic [7:0] a);
      int ai;
      ai = int'(a);
      return (ai >= BASE) && (ai < BASE + 4*NR) && (ai % 4 == 0);
   endfunction

   function automatic int modelIndex(input logic [7:0] a);
      return (int'(a) - BASE) / 4;
   endfunction

   task automatic modelClear();
      for (int k = 0; k < NR; k++) m_regs[k] = '0;
      m_pulse  = '0;
      m_bvalid = 1'b0;
      m_bresp  = '0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_rresp  = '0;
   endtask

   // Whole-interface comparison against the model on every falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < NR; k++)
            checkOutput($sformatf("reg%0d", k), regs_out[k*32 +: 32], m_regs[k]);
         checkOutput("wr_pulse", wr_pulse, m_pulse);
         checkOutput("bvalid", bvalid, m_bvalid);
         if (m_bvalid) checkOutput("bresp", bresp, m_bresp);
         checkOutput("rvalid", rvalid, m_rvalid);
         if (m_rvalid) begin
            checkOutput("rdata", rdata, m_rdata);
            checkOutput("rresp", rresp, m_rresp);
         end
      end
   end

   // Write transaction; lead = cycles W is presented before AW (0 = same cycle)
   task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                                input int lead, input int bready_delay, output logic [2:0] got_bresp);
      bit aw_done, w_done, aw_hs, w_hs, hit;
      int cyc, idx;
      aw_done = 1'b0;
      w_done  = 1'b0;
      cyc     = 0;
      @(posedge clk); #1;
      hit = modelHit(addr);
      idx = modelIndex(addr);
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      wvalid  = 1'b1;
      awvalid = (lead == 0);
      while (!(aw_done && w_done)) begin
         if (cyc >= 40) begin
            checkOutput("write_handshake_timeout", 64'd0, 64'd1);
            awvalid   = 1'b0;
            wvalid    = 1'b0;
            got_bresp = 'x;
            return;
         end
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
         cyc++;
         if (!aw_done && cyc >= lead) awvalid = 1'b1;
         if (w_done && !aw_done) checkOutput("wready_low_waiting_aw", wready, 0);
         if (aw_done && !w_done) checkOutput("awready_low_waiting_w", awready, 0);
      end
      @(posedge clk);
      if (hit) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
         m_pulse = 4'b0001 << idx;
      end
      m_bvalid = 1'b1;
      m_bresp  = hit ? 3'd0 : 3'd2;
      #1;
      got_bresp = bresp;
      for (int i = 0; i <= bready_delay; i++) begin
         if (i == bready_delay) bready = 1'b1;
         else begin
            checkOutput("awready_low_in_resp", awready, 0);
            checkOutput("wready_low_in_resp", wready, 0);
         end
         @(posedge clk);
         m_pulse = '0;
         if (i == bready_delay) m_bvalid = 1'b0;
         #1;
      end
      bready = 1'b0;
      checkOutput("awready_after_b", awready, 1);
      checkOutput("wready_after_b", wready, 1);
   endtask

   task automatic applyReadStimulus(input logic [7:0] addr, input int rready_delay,
                                    output logic [31:0] got_rdata, output logic [2:0] got_rresp);
      int cyc;
      logic [31:0] exp_d;
      logic [2:0]  exp_r;
      cyc = 0;
      @(posedge clk); #1;
      araddr  = addr;
      arvalid = 1'b1;
      while (arready !== 1'b1) begin
         if (cyc >= 40) begin
            checkOutput("read_handshake_timeout", 64'd0, 64'd1);
            arvalid   = 1'b0;
            got_rdata = 'x;
            got_rresp = 'x;
            return;
         end
         @(posedge clk); #1;
         cyc++;
      end
      exp_d = modelHit(addr) ? m_regs[modelIndex(addr)] : 32'd0;
      exp_r = modelHit(addr) ? 3'd0 : 3'd2;
      @(posedge clk);
      m_rvalid = 1'b1;
      m_rdata  = exp_d;
      m_rresp  = exp_r;
      #1;
      arvalid   = 1'b0;
      got_rdata = rdata;
      got_rresp = rresp;
      checkOutput("arready_low_in_resp", arready, 0);
      for (int i = 0; i <= rready_delay; i++) begin
         if (i == rready_delay) rready = 1'b1;
         @(posedge clk);
         if (i == rready_delay) m_rvalid = 1'b0;
         #1;
      end
      rready = 1'b0;
      checkOutput("arready_after_r", arready, 1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_awready"}, awready, 0);
      checkOutput({tag, "_wready"}, wready, 0);
      checkOutput({tag, "_arready"}, arready, 0);
      checkOutput({tag, "_bvalid"}, bvalid, 0);
      checkOutput({tag, "_bresp"}, bresp, 0);
      checkOutput({tag, "_rvalid"}, rvalid, 0);
      checkOutput({tag, "_rdata"}, rdata, 0);
      checkOutput({tag, "_rresp"}, rresp, 0);
      checkOutput({tag, "_regs_lo"}, regs_out[63:0], 0);
      checkOutput({tag, "_regs_hi"}, regs_out[127:64], 0);
      checkOutput({tag, "_wr_pulse"}, wr_pulse, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0]  br;
      logic [31:0] rd;
      logic [2:0]  rr;
      int          cyc;
      aresetn = 1'b0;
      awaddr  = '0; awvalid = 1'b0;
      wdata   = '0; wstrb   = '0; wvalid = 1'b0;
      bready  = 1'b0;
      araddr  = '0; arvalid = 1'b0; rready = 1'b0;
      modelClear();

      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      aresetn = 1'b1;
      checkOutput("awready_before_first_edge", awready, 0);
      @(posedge clk); #1;
      checkOutput("awready_first_edge", awready, 1);
      checkOutput("wready_first_edge", wready, 1);
      checkOutput("arready_first_edge", arready, 1);
      chk_en = 1'b1;

      // AW and W together
      applyStimulus(8'h04, 32'hDEADBEEF, 5'h0F, 0, 0, br);
      checkOutput("t1_bresp", br, 0);
      checkOutput("t1_reg1", regs_out[63:32], 32'hDEADBEEF);

      // W three cycles ahead of AW
      applyStimulus(8'h00, 32'h12345678, 5'h0F, 3, 0, br);
      checkOutput("t2_bresp", br, 0);
      checkOutput("t2_reg0", regs_out[31:0], 32'h12345678);

      // Partial strobe then readback
      applyStimulus(8'h00, 32'hFFFFFFFF, 5'h0F, 0, 0, br);
      applyStimulus(8'h00, 32'h00000000, 5'b00010, 0, 0, br);
      checkOutput("t3_reg0", regs_out[31:0], 32'hFFFF00FF);
      applyReadStimulus(8'h00, 2, rd, rr);
      checkOutput("t3_rdata", rd, 32'hFFFF00FF);
      checkOutput("t3_rresp", rr, 0);

      // Only the ignored strobe MSB set: OKAY, pulse, no data change
      applyStimulus(8'h04, 32'h00000000, 5'h10, 0, 0, br);
      checkOutput("strb0_bresp", br, 0);
      checkOutput("strb0_reg1", regs_out[63:32], 32'hDEADBEEF);

      // Out-of-range and misaligned accesses
      applyStimulus(8'h20, 32'hAAAAAAAA, 5'h0F, 0, 0, br);
      checkOutput("t4_bresp_range", br, 2);
      applyStimulus(8'h06, 32'hBBBBBBBB, 5'h0F, 1, 0, br);
      checkOutput("t4_bresp_misalign", br, 2);
      applyReadStimulus(8'h20, 0, rd, rr);
      checkOutput("t4_rdata", rd, 0);
      checkOutput("t4_rresp", rr, 2);

      // Stalled B with an overlapping read
      fork
         applyStimulus(8'h08, 32'hA5A55A5A, 5'h0F, 0, 5, br);
         begin
            repeat (2) @(posedge clk);
            applyReadStimulus(8'h04, 1, rd, rr);
         end
      join
      checkOutput("t5_bresp", br, 0);
      checkOutput("t5_rdata", rd, 32'hDEADBEEF);
      checkOutput("t5_reg2", regs_out[95:64], 32'hA5A55A5A);

      // Read handshake on the same edge as a commit to the same register
      applyStimulus(8'h0C, 32'h11111111, 5'h0F, 0, 0, br);
      fork
         applyStimulus(8'h0C, 32'h22222222, 5'h0F, 0, 0, br);
         begin
            @(posedge clk);
            applyReadStimulus(8'h0C, 0, rd, rr);
         end
      join
      checkOutput("coll_rdata", rd, 32'h11111111);
      checkOutput("coll_reg3", regs_out[127:96], 32'h22222222);

      // Reset between the AW handshake and W
      @(posedge clk); #1;
      awaddr  = 8'h08;
      awvalid = 1'b1;
      cyc     = 0;
      while (awready !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("t6_awready_seen", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      checkOutput("t6_awready_dropped", awready, 0);
      checkOutput("t6_wready_still_high", wready, 1);
      aresetn = 1'b0;
      @(posedge clk);
      modelClear();
      #1;
      aresetn = 1'b1;
      checkAllZero("t6");
      @(posedge clk); #1;
      checkOutput("t6_awready_back", awready, 1);
      checkOutput("t6_wready_back", wready, 1);
      checkOutput("t6_arready_back", arready, 1);
      repeat (4) @(posedge clk);
      #1;

      applyStimulus(8'h0C, 32'hCAFEF00D, 5'h0F, 2, 0, br);
      checkOutput("post_reset_bresp", br, 0);
      checkOutput("post_reset_reg3", regs_out[127:96], 32'hCAFEF00D);
      checkOutput("post_reset_reg2", regs_out[95:64], 32'h0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
